// File: rtl/axis_vid_gen.sv
`default_nettype none
// ============================================================================
// Module      : axis_vid_gen
// Description : AXI4-Stream raster video source. Emits frames of NUM_LINE
//               lines by NUM_PIX pixels with H_GAP idle cycles between lines
//               and V_GAP idle cycles after each frame, honouring tready.
//               Patterns: H-ramp, V-ramp, checker, constant, 16-bit LFSR.
// Ports       : clk_i, rst_i (sync, active-high)
//               start_i / stop_i / num_frames_i / mode_i / const_i : control
//               axis_t*_o / axis_tready_i : AXI4-Stream master
//               busy_o, done_o, frame_cnt_o : status
// Revision    : 1.0 - initial release
// ============================================================================
module axis_vid_gen #(
    parameter int DATA_W   = 8,
    parameter int NUM_PIX  = 640,
    parameter int NUM_LINE = 512,
    parameter int H_GAP    = 100,
    parameter int V_GAP    = 1000,
    parameter int CHK_LOG2 = 3,
    parameter int KEEP_W   = (DATA_W + 7) / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [15:0]       num_frames_i,
    input  logic [2:0]        mode_i,
    input  logic [DATA_W-1:0] const_i,
    output logic [DATA_W-1:0] axis_tdata_o,
    output logic              axis_tvalid_o,
    input  logic              axis_tready_i,
    output logic [KEEP_W-1:0] axis_tkeep_o,
    output logic              axis_tlast_o,
    output logic              axis_tuser_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int c_XW   = (NUM_PIX  > 1) ? $clog2(NUM_PIX)  : 1;
    localparam int c_YW   = (NUM_LINE > 1) ? $clog2(NUM_LINE) : 1;
    localparam int c_GMAX = (H_GAP > V_GAP) ? H_GAP : V_GAP;
    localparam int c_GW   = (c_GMAX > 1) ? $clog2(c_GMAX) : 1;

    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(NUM_PIX - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(NUM_LINE - 1);
    localparam logic [c_GW-1:0] c_H_LAST = c_GW'((H_GAP > 0) ? H_GAP - 1 : 0);
    localparam logic [c_GW-1:0] c_V_LAST = c_GW'((V_GAP > 0) ? V_GAP - 1 : 0);
    localparam logic [15:0]     c_SEED   = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HGAP   = 2'd2,
        S_VGAP   = 2'd3
    } state_t;

    state_t            r_state, w_state_n;
    logic [c_XW-1:0]   r_x, w_x_n;
    logic [c_YW-1:0]   r_y, w_y_n;
    logic [15:0]       r_lfsr, w_lfsr_n;
    logic [c_GW-1:0]   r_gap, w_gap_n;
    logic [2:0]        r_mode, w_mode_n;
    logic [DATA_W-1:0] r_const, w_const_n;
    logic [15:0]       r_nframes, w_nframes_n;
    logic [15:0]       r_frame_cnt, w_frame_cnt_n;
    logic              r_stop_pend, w_stop_n;
    logic              r_tvalid, w_tvalid_n;
    logic [DATA_W-1:0] r_tdata, w_tdata_n;
    logic              r_tlast, w_tlast_n;
    logic              r_tuser, w_tuser_n;
    logic [KEEP_W-1:0] r_tkeep;
    logic              r_busy, r_done, w_done_n;
    logic              w_accept, w_load, w_end_frame;

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1 (right shift).
    function automatic logic [15:0] f_lfsr(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [DATA_W-1:0] f_pixel(
        input logic [2:0]        mode,
        input logic [DATA_W-1:0] cst,
        input logic [c_XW-1:0]   x,
        input logic [c_YW-1:0]   y,
        input logic [15:0]       lfsr
    );
        case (mode)
            3'd1:    return DATA_W'(y);
            3'd2:    return ((((32'(x) ^ 32'(y)) >> CHK_LOG2) & 32'd1) != 32'd0)
                            ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            3'd3:    return cst;
            3'd4:    return DATA_W'(lfsr);
            default: return DATA_W'(x);
        endcase
    endfunction

    assign w_accept = r_tvalid & axis_tready_i;

    always_comb begin
        w_state_n     = r_state;
        w_x_n         = r_x;
        w_y_n         = r_y;
        w_lfsr_n      = r_lfsr;
        w_gap_n       = r_gap;
        w_mode_n      = r_mode;
        w_const_n     = r_const;
        w_nframes_n   = r_nframes;
        w_frame_cnt_n = r_frame_cnt;
        w_stop_n      = r_stop_pend | (stop_i & (r_state != S_IDLE));
        w_tvalid_n    = r_tvalid;
        w_done_n      = 1'b0;
        w_load        = 1'b0;
        w_end_frame   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_n     = S_ACTIVE;
                    w_x_n         = '0;
                    w_y_n         = '0;
                    w_lfsr_n      = c_SEED;
                    w_gap_n       = '0;
                    w_mode_n      = mode_i;
                    w_const_n     = const_i;
                    w_nframes_n   = num_frames_i;
                    w_frame_cnt_n = 16'd0;
                    w_stop_n      = 1'b0;
                    w_load        = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_accept) begin
                    w_lfsr_n = f_lfsr(r_lfsr);
                    if (r_x != c_X_LAST) begin
                        w_x_n  = r_x + c_XW'(1);
                        w_load = 1'b1;
                    end else begin
                        w_x_n   = '0;
                        w_gap_n = '0;
                        if (r_y != c_Y_LAST) begin
                            w_y_n = r_y + c_YW'(1);
                            if (H_GAP == 0) begin
                                w_load = 1'b1;
                            end else begin
                                w_state_n  = S_HGAP;
                                w_tvalid_n = 1'b0;
                            end
                        end else begin
                            w_y_n         = '0;
                            w_frame_cnt_n = r_frame_cnt + 16'd1;
                            if (V_GAP == 0) begin
                                w_end_frame = 1'b1;
                            end else begin
                                w_state_n  = S_VGAP;
                                w_tvalid_n = 1'b0;
                            end
                        end
                    end
                end
            end
            S_HGAP: begin
                if (r_gap == c_H_LAST) begin
                    w_state_n = S_ACTIVE;
                    w_load    = 1'b1;
                end else begin
                    w_gap_n = r_gap + c_GW'(1);
                end
            end
            S_VGAP: begin
                if (r_gap == c_V_LAST) begin
                    w_end_frame = 1'b1;
                end else begin
                    w_gap_n = r_gap + c_GW'(1);
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // Frame boundary: either finish the run or re-latch pattern controls
        // and present the next SOF beat in the same transition.
        if (w_end_frame) begin
            if (w_stop_n || ((r_nframes != 16'd0) && (w_frame_cnt_n == r_nframes))) begin
                w_state_n  = S_IDLE;
                w_tvalid_n = 1'b0;
                w_done_n   = 1'b1;
                w_stop_n   = 1'b0;
            end else begin
                w_state_n = S_ACTIVE;
                w_mode_n  = mode_i;
                w_const_n = const_i;
                w_load    = 1'b1;
            end
        end

        w_tdata_n = r_tdata;
        w_tlast_n = r_tlast;
        w_tuser_n = r_tuser;
        if (w_load) begin
            w_tvalid_n = 1'b1;
            w_tdata_n  = f_pixel(w_mode_n, w_const_n, w_x_n, w_y_n, w_lfsr_n);
            w_tlast_n  = (w_x_n == c_X_LAST);
            w_tuser_n  = (w_x_n == '0) && (w_y_n == '0);
        end else if (!w_tvalid_n) begin
            w_tdata_n = '0;
            w_tlast_n = 1'b0;
            w_tuser_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x         <= '0;
            r_y         <= '0;
            r_lfsr      <= '0;
            r_gap       <= '0;
            r_mode      <= '0;
            r_const     <= '0;
            r_nframes   <= '0;
            r_frame_cnt <= '0;
            r_stop_pend <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_tkeep     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_x         <= w_x_n;
            r_y         <= w_y_n;
            r_lfsr      <= w_lfsr_n;
            r_gap       <= w_gap_n;
            r_mode      <= w_mode_n;
            r_const     <= w_const_n;
            r_nframes   <= w_nframes_n;
            r_frame_cnt <= w_frame_cnt_n;
            r_stop_pend <= w_stop_n;
            r_tvalid    <= w_tvalid_n;
            r_tdata     <= w_tdata_n;
            r_tlast     <= w_tlast_n;
            r_tuser     <= w_tuser_n;
            r_tkeep     <= {KEEP_W{w_tvalid_n}};
            r_busy      <= (w_state_n != S_IDLE);
            r_done      <= w_done_n;
        end
    end

    assign axis_tdata_o  = r_tdata;
    assign axis_tvalid_o = r_tvalid;
    assign axis_tkeep_o  = r_tkeep;
    assign axis_tlast_o  = r_tlast;
    assign axis_tuser_o  = r_tuser;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign frame_cnt_o   = r_frame_cnt;

endmodule
`default_nettype wire
